// File: rtl/alu_seq_core_pkg.sv
// alu_seq_core shared types: opcodes, FSM states, default geometry.
// Optional feature macro: ALU_SAT_EN (enables the SADD/SSUB saturating opcodes).
package alu_seq_core_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_RF_DEPTH = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SUB  = 4'd3,
    OP_SBB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_LD   = 4'd11,
    OP_MUL  = 4'd12,
    OP_SADD = 4'd13,
    OP_SSUB = 4'd14
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// Operation/data bus between the control unit and alu_seq_core.
// master = control unit side, slave = alu_seq_core.
interface alu_seq_core_if
  import alu_seq_core_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RF_DEPTH = DEF_RF_DEPTH
);
  localparam int RF_AW = $clog2(RF_DEPTH);

  logic              i_op_valid;
  logic              o_op_ready;
  logic [3:0]        i_op_code;
  logic              i_dm_sel;
  logic [DATA_W-1:0] i_dm_data;
  logic              i_direct_load;
  logic [DATA_W-1:0] i_direct_data;
  logic              i_rf_we;
  logic [RF_AW-1:0]  i_rf_waddr;
  logic [RF_AW-1:0]  i_rf_raddr;
  logic [DATA_W-1:0] o_alu;
  logic [DATA_W-1:0] o_acc;
  logic [DATA_W-1:0] o_mul_hi;
  logic [DATA_W-1:0] o_rf_data;
  logic              o_carry;
  logic              o_zero;
  logic              o_done;

  modport master (
    output i_op_valid, i_op_code, i_dm_sel, i_dm_data, i_direct_load,
           i_direct_data, i_rf_we, i_rf_waddr, i_rf_raddr,
    input  o_op_ready, o_alu, o_acc, o_mul_hi, o_rf_data, o_carry, o_zero, o_done
  );

  modport slave (
    input  i_op_valid, i_op_code, i_dm_sel, i_dm_data, i_direct_load,
           i_direct_data, i_rf_we, i_rf_waddr, i_rf_raddr,
    output o_op_ready, o_alu, o_acc, o_mul_hi, o_rf_data, o_carry, o_zero, o_done
  );

endinterface

// File: rtl/alu_seq_core_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle for DATA_W cycles.
// o_done marks the final step; o_product is the value that step produces,
// so the caller can commit it on the same edge the multiplier goes idle.
module alu_seq_mul #(
  parameter int DATA_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_mcand,
  input  logic [DATA_W-1:0]   i_mplier,
  output logic                o_busy,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W:0]     upper_sum;
  logic [2*DATA_W-1:0] prod_step;

  // One shift-add step: conditionally add the multiplicand into the upper half, shift right.
  always_comb begin
    upper_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]};
    if (prod_q[0]) begin
      upper_sum = upper_sum + {1'b0, mcand_q};
    end
    prod_step = {upper_sum, prod_q[DATA_W-1:1]};
  end

  // Partial product starts as {0, multiplier}; down-counter ends the run at terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (i_start && !busy_q) begin
      busy_q  <= 1'b1;
      cnt_q   <= CNT_W'(DATA_W - 1);
      mcand_q <= i_mcand;
      prod_q  <= {{DATA_W{1'b0}}, i_mplier};
    end else if (busy_q) begin
      prod_q <= prod_step;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = busy_q && (cnt_q == '0);
  assign o_product = prod_step;

endmodule

// File: rtl/alu_seq_core.sv
// Accumulator ALU with flags, register file and multi-cycle multiplier.
// Optional feature macro: ALU_SAT_EN (SADD/SSUB unsigned saturation; otherwise they act as LD).
//
//   state   | meaning
//   ST_IDLE | ready; single-cycle ops and direct loads commit on acceptance
//   ST_MUL  | multiplier running; new operations are ignored
module alu_seq_core
  import alu_seq_core_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RF_DEPTH = DEF_RF_DEPTH
) (
  input logic           i_clk,
  input logic           i_rst,
  alu_seq_core_if.slave bus
);

  localparam int RF_AW = $clog2(RF_DEPTH);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   mul_hi_q;
  logic                carry_q;
  logic                zero_q;
  logic                done_q;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic [RF_AW-1:0]    waddr, raddr;

  logic [DATA_W-1:0]   arg;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic                mul_busy;
  logic [2*DATA_W-1:0] mul_product;
  logic [DATA_W:0]     add_w, adc_w, sub_w, sbb_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  assign waddr     = bus.i_rf_waddr;
  assign raddr     = bus.i_rf_raddr;
  assign arg       = bus.i_dm_sel ? bus.i_dm_data : rf_q[raddr];
  assign accept    = bus.i_op_valid && (state_q == ST_IDLE);
  assign mul_start = accept && !bus.i_direct_load && (bus.i_op_code == OP_MUL);

  alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (mul_start),
    .i_mcand   (arg),
    .i_mplier  (acc_q),
    .o_busy    (mul_busy),
    .o_done    (mul_done),
    .o_product (mul_product)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: MUL lasts until the multiplier's final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle result and carry, computed in DATA_W+1 bits.
  always_comb begin
    add_w   = {1'b0, acc_q} + {1'b0, arg};
    adc_w   = add_w + {{DATA_W{1'b0}}, carry_q};
    sub_w   = {1'b0, acc_q} - {1'b0, arg};
    sbb_w   = sub_w - {{DATA_W{1'b0}}, carry_q};
    alu_res = arg;
    alu_c   = carry_q;
    case (bus.i_op_code)
      OP_NOP, OP_MUL: begin alu_res = acc_q;                  alu_c = carry_q;        end
      OP_ADD:         begin alu_res = add_w[DATA_W-1:0];      alu_c = add_w[DATA_W];  end
      OP_ADC:         begin alu_res = adc_w[DATA_W-1:0];      alu_c = adc_w[DATA_W];  end
      OP_SUB:         begin alu_res = sub_w[DATA_W-1:0];      alu_c = sub_w[DATA_W];  end
      OP_SBB:         begin alu_res = sbb_w[DATA_W-1:0];      alu_c = sbb_w[DATA_W];  end
      OP_AND:         begin alu_res = acc_q & arg;            alu_c = 1'b0;           end
      OP_OR:          begin alu_res = acc_q | arg;            alu_c = 1'b0;           end
      OP_XOR:         begin alu_res = acc_q ^ arg;            alu_c = 1'b0;           end
      OP_NOT:         begin alu_res = ~arg;                   alu_c = 1'b0;           end
      OP_SHL:         begin alu_res = {acc_q[DATA_W-2:0], 1'b0}; alu_c = acc_q[DATA_W-1]; end
      OP_SHR:         begin alu_res = {1'b0, acc_q[DATA_W-1:1]}; alu_c = acc_q[0];        end
`ifdef ALU_SAT_EN
      OP_SADD: begin
        alu_res = add_w[DATA_W] ? {DATA_W{1'b1}} : add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
      end
      OP_SSUB: begin
        alu_res = sub_w[DATA_W] ? {DATA_W{1'b0}} : sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
      end
`endif
      default:        begin alu_res = arg;                    alu_c = carry_q;        end
    endcase
  end

  // Accumulator, flags, product high half and the commit pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q    <= '0;
      mul_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (bus.i_direct_load) begin
          acc_q   <= bus.i_direct_data;
          zero_q  <= (bus.i_direct_data == '0);
          carry_q <= 1'b0;
          done_q  <= 1'b1;
        end else if (bus.i_op_code == OP_NOP) begin
          done_q <= 1'b1;
        end else if (bus.i_op_code != OP_MUL) begin
          acc_q   <= alu_res;
          zero_q  <= (alu_res == '0);
          carry_q <= alu_c;
          done_q  <= 1'b1;
        end
      end else if ((state_q == ST_MUL) && mul_done) begin
        acc_q    <= mul_product[DATA_W-1:0];
        mul_hi_q <= mul_product[2*DATA_W-1:DATA_W];
        carry_q  <= |mul_product[2*DATA_W-1:DATA_W];
        zero_q   <= (mul_product == '0);
        done_q   <= 1'b1;
      end
    end
  end

  // Register file: writes the pre-edge accumulator in any state; reads are not bypassed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (bus.i_rf_we) begin
      rf_q[waddr] <= acc_q;
    end
  end

  assign bus.o_op_ready = (state_q == ST_IDLE);
  assign bus.o_alu      = alu_res;
  assign bus.o_acc      = acc_q;
  assign bus.o_mul_hi   = mul_hi_q;
  assign bus.o_rf_data  = rf_q[raddr];
  assign bus.o_carry    = carry_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (DATA_W=8, RF_DEPTH=4).
module tb_alu_seq_core;
  import alu_seq_core_pkg::*;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int MASK = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_core_if #(.DATA_W(W), .RF_DEPTH(D)) bus ();

  alu_seq_core #(.DATA_W(W), .RF_DEPTH(D)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  int m_acc, m_c, m_z, m_hi;
  int m_rf [D];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_op_valid    = 1'b0;
    bus.i_op_code     = 4'd0;
    bus.i_dm_sel      = 1'b0;
    bus.i_dm_data     = '0;
    bus.i_direct_load = 1'b0;
    bus.i_direct_data = '0;
    bus.i_rf_we       = 1'b0;
    bus.i_rf_waddr    = '0;
    bus.i_rf_raddr    = '0;
  endtask

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_z = 1; m_hi = 0;
    for (int i = 0; i < D; i++) m_rf[i] = 0;
  endtask

  task automatic model_op(input int op, input int arg, output int res, output int c);
    int s;
    res = arg;
    c   = m_c;
    case (op)
      OP_NOP, OP_MUL: begin res = m_acc; c = m_c; end
      OP_ADD: begin s = m_acc + arg;       res = s & MASK; c = (s > MASK); end
      OP_ADC: begin s = m_acc + arg + m_c; res = s & MASK; c = (s > MASK); end
      OP_SUB: begin res = (m_acc - arg) & MASK;       c = (m_acc < arg);       end
      OP_SBB: begin res = (m_acc - arg - m_c) & MASK; c = (m_acc < arg + m_c); end
      OP_AND: begin res = m_acc & arg;  c = 0; end
      OP_OR:  begin res = m_acc | arg;  c = 0; end
      OP_XOR: begin res = m_acc ^ arg;  c = 0; end
      OP_NOT: begin res = MASK - arg;   c = 0; end
      OP_SHL: begin res = (m_acc * 2) & MASK; c = m_acc / 128; end
      OP_SHR: begin res = m_acc / 2;          c = m_acc % 2;   end
`ifdef ALU_SAT_EN
      OP_SADD: begin
        s = m_acc + arg;
        if (s > MASK) begin res = MASK; c = 1; end else begin res = s; c = 0; end
      end
      OP_SSUB: begin
        if (m_acc < arg) begin res = 0; c = 1; end else begin res = m_acc - arg; c = 0; end
      end
`endif
      default: begin res = arg; c = m_c; end
    endcase
  endtask

  // One single-cycle (or direct-load) operation; optional simultaneous RF write.
  task automatic do_op(input int op, input bit sel, input int dm, input bit dl, input int dd,
                       input bit we, input int wa, input int ra, input string tag);
    int arg, res, c;
    arg = sel ? dm : m_rf[ra];
    bus.i_op_valid    = 1'b1;
    bus.i_op_code     = 4'(op);
    bus.i_dm_sel      = sel;
    bus.i_dm_data     = 8'(dm);
    bus.i_direct_load = dl;
    bus.i_direct_data = 8'(dd);
    bus.i_rf_we       = we;
    bus.i_rf_waddr    = 2'(wa);
    bus.i_rf_raddr    = 2'(ra);
    #1;
    model_op(op, arg, res, c);
    chk({tag, ".ready"}, bus.o_op_ready, 1);
    chk({tag, ".rf_rd"}, bus.o_rf_data, m_rf[ra]);
    if (op != OP_NOP && op != OP_MUL) chk({tag, ".alu"}, bus.o_alu, res);
    @(posedge clk);
    if (we) m_rf[wa] = m_acc;
    if (dl) begin
      m_acc = dd; m_c = 0; m_z = (dd == 0);
    end else if (op != OP_NOP) begin
      m_acc = res; m_c = c; m_z = (res == 0);
    end
    #1;
    idle_inputs();
    chk({tag, ".acc"},   bus.o_acc,   m_acc);
    chk({tag, ".carry"}, bus.o_carry, m_c);
    chk({tag, ".zero"},  bus.o_zero,  m_z);
    chk({tag, ".done"},  bus.o_done,  1);
  endtask

  // MUL with an ignored ADD request while busy and an RF write to index 3 at we_cycle (0 = none).
  task automatic do_mul(input bit sel, input int dm, input int ra, input int we_cycle, input string tag);
    int arg, p, dones;
    arg = sel ? dm : m_rf[ra];
    p   = m_acc * arg;
    dones = 0;
    bus.i_op_valid = 1'b1;
    bus.i_op_code  = 4'(OP_MUL);
    bus.i_dm_sel   = sel;
    bus.i_dm_data  = 8'(dm);
    bus.i_rf_raddr = 2'(ra);
    @(posedge clk);
    #1;
    chk({tag, ".busy0"}, bus.o_op_ready, 0);
    bus.i_op_code = 4'(OP_ADD);
    bus.i_dm_sel  = 1'b1;
    bus.i_dm_data = 8'h55;
    for (int k = 1; k <= W; k++) begin
      if (k == we_cycle) begin
        bus.i_rf_we    = 1'b1;
        bus.i_rf_waddr = 2'd3;
      end
      @(posedge clk);
      if (k == we_cycle) m_rf[3] = m_acc;
      if (k == W) begin
        m_acc = p & MASK; m_hi = p / 256; m_c = (m_hi != 0); m_z = (p == 0);
      end
      #1;
      bus.i_rf_we = 1'b0;
      if (bus.o_done === 1'b1) dones++;
      if (k < W) chk($sformatf("%s.busy%0d", tag, k), bus.o_op_ready, 0);
      else begin
        idle_inputs();
        chk({tag, ".ready"}, bus.o_op_ready, 1);
      end
    end
    chk({tag, ".acc"},    bus.o_acc,    m_acc);
    chk({tag, ".mul_hi"}, bus.o_mul_hi, m_hi);
    chk({tag, ".carry"},  bus.o_carry,  m_c);
    chk({tag, ".zero"},   bus.o_zero,   m_z);
    @(posedge clk);
    #1;
    if (bus.o_done === 1'b1) dones++;
    chk({tag, ".done_pulses"}, dones, 1);
    chk({tag, ".acc_hold"}, bus.o_acc, m_acc);
  endtask

  initial begin
    int op, sel, dm, dl, we, wa, ra;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state.
    chk("rst.acc",    bus.o_acc,      0);
    chk("rst.zero",   bus.o_zero,     1);
    chk("rst.carry",  bus.o_carry,    0);
    chk("rst.ready",  bus.o_op_ready, 1);
    chk("rst.done",   bus.o_done,     0);
    chk("rst.mul_hi", bus.o_mul_hi,   0);
    for (int i = 0; i < D; i++) begin
      bus.i_rf_raddr = 2'(i);
      #1;
      chk($sformatf("rst.rf%0d", i), bus.o_rf_data, 0);
    end

    // Add/adc chain.
    do_op(OP_ADD, 1, 0, 1, 'hF0, 0, 0, 0, "dl_f0");
    do_op(OP_ADD, 1, 'h20, 0, 0, 0, 0, 0, "add");
    chk("add.acc_10", bus.o_acc, 'h10);
    chk("add.c1",     bus.o_carry, 1);
    do_op(OP_ADC, 1, 'h00, 0, 0, 0, 0, 0, "adc");
    chk("adc.acc_11", bus.o_acc, 'h11);
    chk("adc.c0",     bus.o_carry, 0);

    // Sub/sbb chain.
    do_op(OP_NOP, 1, 0, 1, 'h05, 0, 0, 0, "dl_05");
    do_op(OP_SUB, 1, 'h05, 0, 0, 0, 0, 0, "sub");
    chk("sub.z1", bus.o_zero, 1);
    do_op(OP_SBB, 1, 'h01, 0, 0, 0, 0, 0, "sbb");
    chk("sbb.acc_ff", bus.o_acc, 'hFF);
    chk("sbb.c1",     bus.o_carry, 1);

    // 0xFF * 0xFF with RF write during MUL.
    do_mul(1, 'hFF, 0, 3, "mul_ff");
    chk("mul_ff.acc_01", bus.o_acc, 'h01);
    chk("mul_ff.hi_fe",  bus.o_mul_hi, 'hFE);
    bus.i_rf_raddr = 2'd3;
    #1;
    chk("mul_ff.rf3", bus.o_rf_data, 'hFF);

    // RF write/read same index: no bypass.
    do_op(OP_NOP, 1, 0, 1, 'h3C, 0, 0, 0, "dl_3c");
    bus.i_rf_we    = 1'b1;
    bus.i_rf_waddr = 2'd2;
    bus.i_rf_raddr = 2'd2;
    #1;
    chk("rf.same_cycle", bus.o_rf_data, 'h00);
    @(posedge clk);
    m_rf[2] = m_acc;
    #1;
    bus.i_rf_we = 1'b0;
    chk("rf.next_cycle", bus.o_rf_data, 'h3C);

    // NOP keeps everything, still pulses done.
    do_op(OP_NOP, 1, 'h77, 0, 0, 0, 0, 0, "nop");

    // Saturating add (acts as LD without the feature).
    do_op(OP_NOP, 1, 0, 1, 'hF0, 0, 0, 0, "dl_f0b");
    do_op(OP_SADD, 1, 'h20, 0, 0, 0, 0, 0, "sadd");
    do_op(OP_SSUB, 1, 'h30, 0, 0, 0, 0, 0, "ssub");

    // Randomized operations against the reference model.
    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 15);
      sel = $urandom_range(0, 1);
      dm  = $urandom_range(0, MASK);
      dl  = ($urandom_range(0, 7) == 0);
      we  = $urandom_range(0, 1);
      wa  = $urandom_range(0, D - 1);
      ra  = $urandom_range(0, D - 1);
      if (op == OP_MUL && !dl)
        do_mul(sel[0], dm, ra, $urandom_range(0, W), $sformatf("rmul%0d", n));
      else
        do_op(op, sel[0], dm, dl[0], $urandom_range(0, MASK), we[0], wa, ra,
              $sformatf("rnd%0d_op%0d", n, op));
    end

    // Reset during MUL cycle 4.
    do_op(OP_NOP, 1, 0, 1, 'h9A, 1, 1, 0, "dl_9a");
    bus.i_op_valid = 1'b1;
    bus.i_op_code  = 4'(OP_MUL);
    bus.i_dm_sel   = 1'b1;
    bus.i_dm_data  = 8'h07;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("rmul.busy", bus.o_op_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rmul.acc",   bus.o_acc,      0);
    chk("rmul.ready", bus.o_op_ready, 1);
    chk("rmul.zero",  bus.o_zero,     1);
    chk("rmul.hi",    bus.o_mul_hi,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rmul.no_done%0d", k), bus.o_done, 0);
    end
    chk("rmul.acc_after", bus.o_acc, 0);
    bus.i_rf_raddr = 2'd1;
    #1;
    chk("rmul.rf1_cleared", bus.o_rf_data, 0);
    do_op(OP_ADD, 1, 'h21, 0, 0, 0, 0, 0, "post_rst_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
